// File: rtl/if_stage_q.sv
// if_stage_q: instruction fetch stage with credit-based prefetch FIFO
// feeding decode, tagging each ROM word with its PC.
module if_stage_q #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     is_flush,
    input  logic [31:0]              branch_target,
    input  logic                     is_stall,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [31:0]              mem_instr,
    output logic                     is_valid,
    output logic [31:0]              pc,
    output logic [31:0]              instr,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    logic [31:0]   fetch_pc_q, inflight_pc_q;
    logic          inflight_q;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   count_q;
    logic [PW+1:0] credit;
    logic          push, pop;
    // the in-flight word already owns a slot, so it is part of the credit
    assign credit     = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q};
    assign mem_req    = !is_flush && credit < (PW+2)'(DEPTH);
    assign mem_addr   = fetch_pc_q[ADDR_W+1:2];
    assign is_valid   = count_q != '0;
    assign push       = inflight_q && !is_flush;
    assign pop        = is_valid && !is_stall && !is_flush;
    assign pc         = is_valid ? pc_mem_q[rd_q] : '0;
    assign instr      = is_valid ? instr_mem_q[rd_q] : '0;
    assign fifo_count = count_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_q          <= '0;
            wr_q          <= '0;
            count_q       <= '0;
        end else if (is_flush) begin
            fetch_pc_q <= {branch_target[31:2], 2'b00};
            inflight_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= mem_req;
            if (mem_req) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + 32'd4;
            end
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_q]    <= inflight_pc_q;
            instr_mem_q[wr_q] <= mem_instr;
        end
    end
endmodule

// File: tb/tb_if_stage_q.sv
// tb_if_stage_q: table-driven check of if_stage_q against a ROM whose
// word k holds k+100, plus hand sequences for async reset and address wrap.
module tb_if_stage_q;
    logic        clk = 1'b0;
    logic        reset, is_flush, is_stall;
    logic [31:0] branch_target;
    logic        mem_req, mem_req2;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_addr2;
    logic [31:0] mem_instr, mem_instr2;
    logic        is_valid, is_valid2;
    logic [31:0] pc, instr, pc2, instr2;
    logic [2:0]  fifo_count, fifo_count2;
    int          checks = 0;
    int          failures = 0;

    if_stage_q #(.ADDR_W(10), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .is_flush(is_flush), .branch_target(branch_target),
        .is_stall(is_stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_instr(mem_instr),
        .is_valid(is_valid), .pc(pc), .instr(instr), .fifo_count(fifo_count)
    );

    if_stage_q #(.ADDR_W(4), .DEPTH(4), .RESET_PC(32'h0)) dut2 (
        .clk(clk), .reset(reset), .is_flush(is_flush), .branch_target(branch_target),
        .is_stall(is_stall), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_instr(mem_instr2),
        .is_valid(is_valid2), .pc(pc2), .instr(instr2), .fifo_count(fifo_count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req) mem_instr <= 32'(mem_addr) + 32'd100;
        if (mem_req2) mem_instr2 <= 32'(mem_addr2) + 32'd100;
    end

    typedef struct {
        logic        r, f, s;
        logic [31:0] bt;
        logic        v;
        logic [31:0] epc, einstr;
        int          cnt;
        int          req;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, f, s, input logic [31:0] bt, input logic v,
                       input logic [31:0] epc, einstr, input int cnt, req);
        vec_t t;
        t.r = r; t.f = f; t.s = s; t.bt = bt; t.v = v;
        t.epc = epc; t.einstr = einstr; t.cnt = cnt; t.req = req;
        vecs.push_back(t);
    endtask

    initial begin
        reset = 1'b0; is_flush = 1'b0; is_stall = 1'b0; branch_target = '0;
        // reset release, free-running fetch (req=2 means not checked)
        add(1,0,0,0,        0,0,0,0,2);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,0,0,        1,0,100,1,1);
        add(0,0,0,0,        1,4,101,1,1);
        add(0,0,0,0,        1,8,102,1,1);
        add(0,0,0,0,        1,12,103,1,1);
        // sustained stall fills the FIFO, then drains with no gap
        add(1,0,0,0,        0,0,0,0,2);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,1,0,        1,0,100,1,1);
        add(0,0,1,0,        1,0,100,2,1);
        add(0,0,1,0,        1,0,100,3,0);
        add(0,0,1,0,        1,0,100,4,0);
        add(0,0,0,0,        1,0,100,4,0);
        add(0,0,0,0,        1,4,101,3,1);
        add(0,0,0,0,        1,8,102,2,1);
        add(0,0,0,0,        1,12,103,2,1);
        add(0,0,0,0,        1,16,104,2,1);
        // flush with 3 queued plus one in flight
        add(1,0,0,0,        0,0,0,0,2);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,1,0,        1,0,100,1,1);
        add(0,0,1,0,        1,0,100,2,1);
        add(0,1,1,32'h200,  1,0,100,3,0);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,0,0,        1,32'h200,228,1,1);
        add(0,0,0,0,        1,32'h204,229,1,1);
        // flush overrides stall; unaligned target is word aligned
        add(0,1,1,32'h103,  1,32'h208,230,1,0);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,0,0,        0,0,0,0,1);
        add(0,0,0,0,        1,32'h100,164,1,1);
        add(0,0,0,0,        1,32'h104,165,1,1);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].r; is_flush = vecs[i].f; is_stall = vecs[i].s;
            branch_target = vecs[i].bt;
            #1;
            chk("is_valid", i, 32'(is_valid), 32'(vecs[i].v));
            chk("pc", i, pc, vecs[i].epc);
            chk("instr", i, instr, vecs[i].einstr);
            chk("fifo_count", i, 32'(fifo_count), 32'(vecs[i].cnt));
            if (vecs[i].req != 2) chk("mem_req", i, 32'(mem_req), 32'(vecs[i].req));
            step();
        end
        // asynchronous reset mid-stream with a full FIFO
        reset = 1'b1; is_flush = 1'b0; is_stall = 1'b0; branch_target = '0;
        step();
        reset = 1'b0;
        step(); step();
        is_stall = 1'b1;
        step(); step(); step();
        chk("full_count", 0, 32'(fifo_count), 32'd4);
        chk("full_req", 0, 32'(mem_req), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", 0, 32'(is_valid), 32'd0);
        chk("async_pc", 0, pc, 32'd0);
        chk("async_instr", 0, instr, 32'd0);
        chk("async_count", 0, 32'(fifo_count), 32'd0);
        step();
        reset = 1'b0; is_stall = 1'b0;
        #1;
        chk("restart_req", 0, 32'(mem_req), 32'd1);
        chk("restart_addr", 0, 32'(mem_addr), 32'd0);
        chk("restart_valid0", 0, 32'(is_valid), 32'd0);
        step();
        chk("restart_valid1", 1, 32'(is_valid), 32'd0);
        step();
        chk("restart_valid2", 2, 32'(is_valid), 32'd1);
        chk("restart_pc2", 2, pc, 32'd0);
        chk("restart_instr2", 2, instr, 32'd100);
        // narrow ROM address wraps while the PC keeps counting
        for (int c = 3; c <= 15; c++) step();
        chk("wrap_addr15", 15, 32'(mem_addr2), 32'd15);
        step();
        chk("wrap_addr16", 16, 32'(mem_addr2), 32'd0);
        step();
        chk("wrap_pc17", 17, pc2, 32'h3C);
        chk("wrap_instr17", 17, instr2, 32'd115);
        step();
        chk("wrap_pc18", 18, pc2, 32'h40);
        chk("wrap_instr18", 18, instr2, 32'd100);
        chk("wide_instr18", 18, instr, 32'd116);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage_q.md
# if_stage_q

Parametrised instruction-fetch stage with a prefetch queue. It drives an external synchronous instruction ROM and tags each returned word with its PC. Fetched words are buffered in a FIFO so the decode stage can stall without losing or re-fetching instructions. A flush redirects fetch to a branch target and discards everything already fetched or in flight.

## Interface
Parameters:
- ADDR_W, 10: ROM word-address width; ROM holds 2^ADDR_W words.
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch PC loaded by reset; word aligned.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- is_flush, input, 1: redirect fetch to branch_target; highest priority after reset.
- branch_target, input, 32: new fetch PC; bits [1:0] ignored (forced 0).
- is_stall, input, 1: decode not accepting; head entry is held.
- mem_req, output, 1: ROM read enable this cycle.
- mem_addr, output, ADDR_W: ROM word address, equal to fetch_pc[ADDR_W+1:2].
- mem_instr, input, 32: ROM data, valid the cycle after mem_req.
- is_valid, output, 1: FIFO head holds a valid instruction.
- pc, output, 32: PC of the head entry; 0 when is_valid=0.
- instr, output, 32: head instruction; 0 when is_valid=0.
- fifo_count, output, $clog2(DEPTH)+1: number of occupied entries.

## Operation
- State:
  - fetch_pc (32 bits).
  - inflight flag plus inflight_pc.
  - FIFO register array of {pc, instr} entries, with read/write pointers and a count.
- Request:
  - mem_req = !is_flush && (fifo_count + inflight) < DEPTH. The credit check counts the in-flight word, so the FIFO can never overflow.
  - On a clock edge with mem_req=1: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - On an edge with mem_req=0: inflight<=0.
- Response: on an edge with inflight=1 and no flush, write {inflight_pc, mem_instr} at the write pointer.
- Pop: on an edge with is_valid && !is_stall && !is_flush, advance the read pointer.
- A push and a pop on the same edge leave count unchanged. A pop in the same cycle does not add credit; credit is evaluated on pre-edge values.
- Flush: on an edge with is_flush=1:
  - fetch_pc<={branch_target[31:2],2'b00}.
  - FIFO emptied (pointers and count reset).
  - inflight<=0, so the returning word is discarded.
  - Any concurrent push or pop is ignored.
- Priority: reset > is_flush > push/pop. Flush overrides stall.
- Output gating: head outputs are read combinationally from the FIFO array and gated to 0 when the FIFO is empty.
- Arithmetic and wrap-around:
  - fetch_pc is 32-bit modulo 2^32.
  - mem_addr wraps naturally every 2^ADDR_W words; pc reports the full 32 bits.
  - FIFO pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, any time, including mid-flush or mid-stall):
  - fetch_pc=RESET_PC, inflight=0, FIFO empty.
  - Immediately is_valid=0, pc=0, instr=0, fifo_count=0.
  - mem_req=1 and mem_addr=RESET_PC[ADDR_W+1:2] as soon as reset deasserts.
- Fetch latency: request in cycle N, ROM data in cycle N+1, written at the end of N+1, visible at the head in cycle N+2. After reset release, the first is_valid=1 is the 2nd cycle after the release edge.
- Throughput:
  - With is_stall=0, one instruction per cycle in steady state (count 1, inflight 1).
  - Under sustained stall, the FIFO fills to DEPTH and mem_req then stays 0.
- Flush at cycle T:
  - is_valid=0 in T+1.
  - mem_req for the target in T+1.
  - is_valid=1 with pc=target in T+3.
- Stall release: the head pops on the first edge with is_stall=0. The next entry appears the following cycle with no bubble if the FIFO holds at least 2 entries.

## Test plan
- Reset release with RESET_PC=0 and ROM word k=k+100, is_stall=0: is_valid rises 2 cycles after release; pc sequence 0,4,8,12; instr sequence 100,101,102,103.
- Hold is_stall=1 from the first valid cycle, DEPTH=4: fifo_count reaches 4 and mem_req=0, pc held at 0. Release the stall: pc 0,4,8,12,16 on consecutive cycles with no gap and no duplicates.
- is_flush with branch_target=0x200 while 3 entries are queued and one word is in flight: next cycle is_valid=0 and fifo_count=0; 3 cycles after flush, pc=0x200, then 0x204. No pre-flush PC ever appears.
- is_flush and is_stall together, branch_target=0x103: flush wins; first valid pc=0x100.
- ADDR_W=4, run fetch past pc=0x3C: mem_addr wraps 15→0 while pc reports 0x40.
- Assert reset for 1 cycle mid-stream with a full FIFO: outputs clear immediately without waiting for a clock edge; the sequence restarts at RESET_PC with the normal 2-cycle latency.
